// File: rtl/barrel_rotl_seq_amisha_if.sv
// Request/result bundle for the sequential rotate-left unit.
// start_amisha is accepted only while busy_amisha=0. done_amisha is a one-cycle pulse aligned with the new y_amisha.
interface barrel_rotl_seq_amisha_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
);
  logic             start_amisha;
  logic [WIDTH-1:0] a_amisha;
  logic [AMT_W-1:0] amt_amisha;
  logic [WIDTH-1:0] y_amisha;
  logic             busy_amisha;
  logic             done_amisha;

  modport master (
    output start_amisha, a_amisha, amt_amisha,
    input  y_amisha, busy_amisha, done_amisha
  );

  modport slave (
    input  start_amisha, a_amisha, amt_amisha,
    output y_amisha, busy_amisha, done_amisha
  );
endinterface

// File: rtl/barrel_rotl_seq_amisha.sv
// Sequential rotate-left: captures operand/amount on start, rotates one bit per clock,
// then presents the result with a one-cycle done pulse (latency amt+1).
module barrel_rotl_seq_amisha #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic                     clk_amisha,
  input  logic                     reset_amisha,
  barrel_rotl_seq_amisha_if.slave  bus,
  output logic [1:0]               o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_work;
  logic [AMT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] w_rot;
  logic             w_busy;
  logic             w_done;
  logic             w_amt_zero;
  logic             w_last;

  assign w_rot      = {r_work[WIDTH-2:0], r_work[WIDTH-1]};
  assign w_amt_zero = (bus.amt_amisha == '0);
  assign w_last     = (r_cnt == AMT_W'(1));

  always_ff @(posedge clk_amisha) begin
    if (reset_amisha) r_state <= S_IDLE;
    else              r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start_amisha) w_next = w_amt_zero ? S_DONE : S_SHIFT;
      S_SHIFT: if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_SHIFT: w_busy = 1'b1;
      S_DONE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
      end
      default: ;
    endcase
  end

  // y is written only on the edge that enters DONE, so it stays stable while shifting.
  always_ff @(posedge clk_amisha) begin
    if (reset_amisha) begin
      r_work <= '0;
      r_cnt  <= '0;
      r_y    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start_amisha) begin
            r_work <= bus.a_amisha;
            r_cnt  <= bus.amt_amisha;
            if (w_amt_zero) r_y <= bus.a_amisha;
          end
        end
        S_SHIFT: begin
          r_work <= w_rot;
          r_cnt  <= r_cnt - AMT_W'(1);
          if (w_last) r_y <= w_rot;
        end
        default: ;
      endcase
    end
  end

  assign bus.y_amisha    = r_y;
  assign bus.busy_amisha = w_busy;
  assign bus.done_amisha = w_done;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_barrel_rotl_seq_amisha.sv
// Directed bench for barrel_rotl_seq_amisha: vector table, busy/reset corner sequences,
// and the rotate-right/rotate-left inverse loop over every operand and amount.
module tb_barrel_rotl_seq_amisha;

  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;
  int         n_checks;
  int         n_fail;

  barrel_rotl_seq_amisha_if #(.WIDTH(8), .AMT_W(3)) bus ();

  barrel_rotl_seq_amisha #(.WIDTH(8), .AMT_W(3)) dut (
    .clk_amisha   (clk),
    .reset_amisha (reset),
    .bus          (bus.slave),
    .o_dbg_state  (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [2:0] amt;
    logic [7:0] exp_y;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rotr8(input logic [7:0] a, input logic [2:0] amt);
    logic [15:0] dbl;
    dbl = {a, a} >> amt;
    return dbl[7:0];
  endfunction

  // Launch one op, check busy and y stability while running, then latency, result and the pulse width.
  task automatic run_op(input logic [7:0] a, input logic [2:0] amt, input logic [7:0] exp_y);
    logic [7:0] y_prev;
    int         j;
    bit         seen;
    @(negedge clk);
    y_prev           = bus.y_amisha;
    bus.start_amisha = 1'b1;
    bus.a_amisha     = a;
    bus.amt_amisha   = amt;
    @(negedge clk);
    bus.start_amisha = 1'b0;
    bus.a_amisha     = 8'($urandom_range(0, 255));
    bus.amt_amisha   = 3'($urandom_range(0, 7));
    j    = 0;
    seen = 1'b0;
    while (!seen && j < 20) begin
      if (bus.done_amisha) seen = 1'b1;
      else begin
        chk("busy_during_op", 32'(bus.busy_amisha), 32'd1);
        chk("y_stable_during_op", 32'(bus.y_amisha), 32'(y_prev));
        @(negedge clk);
        j++;
      end
    end
    if (!seen) chk("done_timeout", 32'(seen), 32'd1);
    else begin
      chk("latency", 32'(j + 1), 32'(amt) + 32'd1);
      chk("y_result", 32'(bus.y_amisha), 32'(exp_y));
      chk("busy_at_done", 32'(bus.busy_amisha), 32'd1);
      @(negedge clk);
      chk("done_one_cycle", 32'(bus.done_amisha), 32'd0);
      chk("idle_after_done", 32'(bus.busy_amisha), 32'd0);
      chk("y_held", 32'(bus.y_amisha), 32'(exp_y));
    end
  endtask

  initial begin
    int n_done;
    bit seen;
    n_checks = 0;
    n_fail   = 0;
    bus.start_amisha = 1'b0;
    bus.a_amisha     = 8'h00;
    bus.amt_amisha   = 3'd0;
    reset            = 1'b1;

    vecs[0] = '{8'hB1, 3'd3, 8'h8D};
    vecs[1] = '{8'h5A, 3'd0, 8'h5A};
    vecs[2] = '{8'h01, 3'd7, 8'h80};
    vecs[3] = '{8'h0F, 3'd4, 8'hF0};
    vecs[4] = '{8'hC3, 3'd2, 8'h0F};
    vecs[5] = '{8'h80, 3'd1, 8'h01};
    vecs[6] = '{8'hA5, 3'd5, 8'hB4};
    vecs[7] = '{8'h3C, 3'd4, 8'hC3};
    vecs[8] = '{8'hFF, 3'd6, 8'hFF};
    vecs[9] = '{8'h12, 3'd1, 8'h24};

    // Reset held two cycles, then idle with no start.
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("reset_y", 32'(bus.y_amisha), 32'h00);
      chk("reset_busy", 32'(bus.busy_amisha), 32'd0);
      chk("reset_done", 32'(bus.done_amisha), 32'd0);
      chk("reset_state", 32'(dbg_state), 32'd0);
    end

    for (int i = 0; i < 10; i++) run_op(vecs[i].a, vecs[i].amt, vecs[i].exp_y);

    // Starts during SHIFT and during DONE are dropped; a start right after DONE is taken.
    @(negedge clk);
    bus.start_amisha = 1'b1;
    bus.a_amisha     = 8'h0F;
    bus.amt_amisha   = 3'd4;
    n_done = 0;
    for (int j = 0; j <= 5; j++) begin
      @(negedge clk);
      if (bus.done_amisha) begin
        n_done++;
        chk("ignore_y", 32'(bus.y_amisha), 32'hF0);
      end
      case (j)
        0: begin
          bus.start_amisha = 1'b0;
          chk("ignore_busy", 32'(bus.busy_amisha), 32'd1);
        end
        1: begin
          bus.start_amisha = 1'b1;
          bus.a_amisha     = 8'hFF;
          bus.amt_amisha   = 3'd1;
        end
        2: bus.start_amisha = 1'b0;
        4: begin
          bus.start_amisha = 1'b1;
          bus.a_amisha     = 8'hFF;
          bus.amt_amisha   = 3'd1;
        end
        5: begin
          chk("ignore_idle_busy", 32'(bus.busy_amisha), 32'd0);
          chk("ignore_idle_done", 32'(bus.done_amisha), 32'd0);
          chk("ignore_y_held", 32'(bus.y_amisha), 32'hF0);
          bus.a_amisha   = 8'h81;
          bus.amt_amisha = 3'd1;
        end
        default: ;
      endcase
    end
    chk("ignore_single_done", 32'(n_done), 32'd1);
    @(negedge clk);
    bus.start_amisha = 1'b0;
    chk("after_done_accept", 32'(bus.busy_amisha), 32'd1);
    seen = 1'b0;
    for (int j = 0; j < 5 && !seen; j++) begin
      @(negedge clk);
      if (bus.done_amisha) begin
        seen = 1'b1;
        chk("after_done_y", 32'(bus.y_amisha), 32'h03);
      end
    end
    chk("after_done_seen", 32'(seen), 32'd1);

    // Reset on the third SHIFT cycle aborts the op without a done pulse.
    @(negedge clk);
    bus.start_amisha = 1'b1;
    bus.a_amisha     = 8'hC3;
    bus.amt_amisha   = 3'd6;
    n_done = 0;
    for (int j = 0; j <= 2; j++) begin
      @(negedge clk);
      bus.start_amisha = 1'b0;
      if (bus.done_amisha) n_done++;
    end
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_busy", 32'(bus.busy_amisha), 32'd0);
    chk("midreset_done", 32'(bus.done_amisha), 32'd0);
    chk("midreset_y", 32'(bus.y_amisha), 32'h00);
    chk("midreset_state", 32'(dbg_state), 32'd0);
    reset = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (bus.done_amisha) n_done++;
    end
    chk("midreset_no_done", 32'(n_done), 32'd0);
    run_op(8'hC3, 3'd2, 8'h0F);

    // Rotate-left undoes rotate-right for every operand and amount.
    for (int a = 0; a < 256; a++) begin
      for (int m = 0; m < 8; m++) begin
        run_op(rotr8(8'(a), 3'(m)), 3'(m), 8'(a));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
